instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Purpose:
//   Fetch stage of a simple in-order pipeline. It drives a word address (pc)
//   to a zero-latency instruction memory and captures the returned word into
//   the IF/ID pipeline register. It supports branch redirects from execute,
//   downstream stalls, and an optional halt when an all-zero word is fetched.
//
// Parameters:
//   RESET_PC      word address loaded into pc on reset
//   HALT_ON_ZERO  1: an all-zero fetched word stops fetch (HALT state)
//                 0: an all-zero word is fetched as an ordinary nop
//
// Ports:
//   clk            in   1   clock, all state changes on the rising edge
//   reset          in   1   asynchronous active-high reset
//   stall          in   1   downstream not ready, hold fetch state
//   branch_taken   in   1   redirect request from execute
//   branch_target  in   8   redirect word address
//   pc             out  8   word address driven to instruction memory
//   instruction    in   32  memory word for the current pc (combinational)
//   if_instr       out  32  IF/ID instruction register
//   if_pc_plus1    out  8   IF/ID pc+1 of the fetched word
//   if_valid       out  1   if_instr holds a real instruction (0 = bubble)
//   halted         out  1   fetch stopped on a zero word
//   fetch_count    out  16  words accepted into IF/ID, saturating
// -----------------------------------------------------------------------------
module instruction_fetch #(
    parameter logic [7:0] RESET_PC     = 8'd0,
    parameter logic       HALT_ON_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [7:0]  branch_target,
    output logic [7:0]  pc,
    input  logic [31:0] instruction,
    output logic [31:0] if_instr,
    output logic [7:0]  if_pc_plus1,
    output logic        if_valid,
    output logic        halted,
    output logic [15:0] fetch_count
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

    // State registers
    logic [0:0]  r_state;
    logic [7:0]  r_pc;
    logic [31:0] r_if_instr;
    logic [7:0]  r_if_pc_plus1;
    logic        r_if_valid;
    logic [15:0] r_fetch_count;

    // Next-state values
    logic [0:0]  w_state_next;
    logic [7:0]  w_pc_next;
    logic [31:0] w_if_instr_next;
    logic [7:0]  w_if_pc_plus1_next;
    logic        w_if_valid_next;
    logic [15:0] w_fetch_count_next;

    // Helpers
    logic [7:0]  w_pc_plus1;
    logic [15:0] w_count_inc;
    logic        w_zero_word;
    logic        w_halt_enable;

    // 8-bit add wraps 255 -> 0 naturally.
    assign w_pc_plus1    = r_pc + 8'd1;
    // Counter sticks at its maximum instead of wrapping.
    assign w_count_inc   = (r_fetch_count == COUNT_MAX) ? r_fetch_count
                                                        : r_fetch_count + 16'd1;
    assign w_zero_word   = (instruction == 32'h0000_0000);
    assign w_halt_enable = (HALT_ON_ZERO == 1'b1);

    // Priority: branch > stall > HALT hold > halt detection > normal fetch.
    always_comb begin
        w_state_next       = r_state;
        w_pc_next          = r_pc;
        w_if_instr_next    = r_if_instr;
        w_if_pc_plus1_next = r_if_pc_plus1;
        w_if_valid_next    = r_if_valid;
        w_fetch_count_next = r_fetch_count;

        if (branch_taken) begin
            // Redirect flushes the slot being fetched and leaves HALT.
            w_pc_next       = branch_target;
            w_if_instr_next = 32'h0000_0000;
            w_if_valid_next = 1'b0;
            w_state_next    = ST_RUN;
        end else if (stall) begin
            // Hold everything.
        end else if (r_state == ST_HALT) begin
            // Parked until a branch arrives; if_valid is already 0.
        end else if (w_halt_enable && w_zero_word) begin
            // Zero word: stop without consuming it, pc stays on it.
            w_state_next    = ST_HALT;
            w_if_instr_next = 32'h0000_0000;
            w_if_valid_next = 1'b0;
        end else begin
            w_if_instr_next    = instruction;
            w_if_pc_plus1_next = w_pc_plus1;
            w_if_valid_next    = 1'b1;
            w_pc_next          = w_pc_plus1;
            w_fetch_count_next = w_count_inc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_pc          <= RESET_PC;
            r_if_instr    <= 32'h0000_0000;
            r_if_pc_plus1 <= 8'd0;
            r_if_valid    <= 1'b0;
            r_fetch_count <= 16'd0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_if_instr    <= w_if_instr_next;
            r_if_pc_plus1 <= w_if_pc_plus1_next;
            r_if_valid    <= w_if_valid_next;
            r_fetch_count <= w_fetch_count_next;
        end
    end

    assign pc          = r_pc;
    assign if_instr    = r_if_instr;
    assign if_pc_plus1 = r_if_pc_plus1;
    assign if_valid    = r_if_valid;
    assign halted      = (r_state == ST_HALT);
    assign fetch_count = r_fetch_count;

endmodule
